// File: rtl/in_port_fifo_if.sv
// Handshake and bus-mux signals for the input-port FIFO.
// The StatusOut strobe exists only when INPORT_STATUS_EN is defined.
interface in_port_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
);
  logic [WIDTH-1:0] ext_data;
  logic             ext_valid;
  logic             ext_ready;
  logic             InPortIn;
  logic             InPortOut;
`ifdef INPORT_STATUS_EN
  logic             StatusOut;
`endif
  logic [WIDTH-1:0] BusMuxIn;
  logic             data_avail;
  logic [CW-1:0]    count;
  logic             underflow;

  // The master side is the producer plus the control unit.
  modport master (
`ifdef INPORT_STATUS_EN
    output StatusOut,
`endif
    output ext_data, ext_valid, InPortIn, InPortOut,
    input  ext_ready, BusMuxIn, data_avail, count, underflow
  );

  modport slave (
`ifdef INPORT_STATUS_EN
    input  StatusOut,
`endif
    input  ext_data, ext_valid, InPortIn, InPortOut,
    output ext_ready, BusMuxIn, data_avail, count, underflow
  );
endinterface

// File: rtl/in_port_fifo.sv
// Input-port front end: valid/ready producer FIFO feeding the InPort holding register.
// Optional status word on the bus mux when INPORT_STATUS_EN is defined.
module in_port_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic           Clock,
  input logic           Clear,
  in_port_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_inport;
  logic             r_underflow;

  logic             w_ready;
  logic             w_avail;
  logic             w_push;
  logic             w_pop;

  // Flags come from the occupancy register only, so no input reaches them combinationally.
  assign w_ready = (r_count != CW'(DEPTH));
  assign w_avail = (r_count != '0);
  assign w_push  = bus.ext_valid && w_ready;
  assign w_pop   = bus.InPortIn && w_avail;

  // NOTE: the storage array has no reset; validity is tracked by the pointers and count, so resetting it would only cost flops.
  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wp] <= bus.ext_data;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_inport    <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) begin
        r_rp        <= r_rp + AW'(1);
        r_inport    <= r_mem[r_rp];
        r_underflow <= 1'b0;
      end else if (bus.InPortIn) begin
        r_underflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef INPORT_STATUS_EN
  logic [WIDTH-1:0] w_status;

  always_comb begin
    w_status          = '0;
    w_status[CW+2:0]  = {r_underflow, ~w_ready, ~w_avail, r_count};
  end

  // InPortOut takes priority over a status read.
  always_comb begin
    if (bus.InPortOut)      bus.BusMuxIn = r_inport;
    else if (bus.StatusOut) bus.BusMuxIn = w_status;
    else                    bus.BusMuxIn = '0;
  end
`else
  assign bus.BusMuxIn = bus.InPortOut ? r_inport : '0;
`endif

  assign bus.ext_ready  = w_ready;
  assign bus.data_avail = w_avail;
  assign bus.count      = r_count;
  assign bus.underflow  = r_underflow;
endmodule

// File: doc/in_port_fifo.md
# in_port_fifo

- Input-port front end for the datapath; receiver side of the port pair whose transmit side is the out-port register loaded by OutPortIn.
- Accepts 32-bit words from an external producer over a valid/ready handshake into a small FIFO.
- On InPortIn, pops the FIFO head into the InPort holding register; on InPortOut, drives that register onto the bus-mux input.
- Sits between the external device and the datapath bus mux, controlled by the same control-unit strobes as the other registers.

## Interface
Parameters:
- WIDTH, 32, data width of port, FIFO and holding register
- DEPTH, 4, FIFO entries; power of two, ≥2
- CW, $clog2(DEPTH)+1, width of `count`

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Clear  in  1  reset, asynchronous and active-low
- ext_data  in  WIDTH  producer data
- ext_valid  in  1  producer has a word on ext_data
- ext_ready  out  1  FIFO can accept; equals !full
- InPortIn  in  1  pop FIFO head into InPort register
- InPortOut  in  1  drive InPort register onto BusMuxIn
- BusMuxIn  out  WIDTH  bus-mux contribution; zero when not selected
- data_avail  out  1  FIFO not empty
- count  out  CW  FIFO occupancy, 0..DEPTH
- underflow  out  1  sticky: InPortIn issued while FIFO empty

## Operation
- Storage: DEPTH×WIDTH array; write pointer `wp`, read pointer `rp`, each log2(DEPTH) bits, wrapping modulo DEPTH; occupancy register `count`.
- Push: when ext_valid && ext_ready at a rising edge, mem[wp] ← ext_data, wp+1, count+1.
- Pop: when InPortIn && count≠0 at a rising edge, InPort ← mem[rp], rp+1, count−1, underflow ← 0.
- Empty pop: InPortIn && count==0 leaves InPort unchanged, pointers unchanged, underflow ← 1.
- Simultaneous push and pop with 0<count<DEPTH: both occur, count unchanged.
- count==DEPTH: ext_ready=0, so no push, even if a pop occurs in the same cycle (no full bypass). The push lands on the next edge.
- count==0 with push and InPortIn in the same cycle: the push occurs and the pop is treated as an empty pop (no empty bypass), so underflow ← 1.
- Output mux:
  - BusMuxIn = InPort when InPortOut=1, else 0.
  - Purely combinational from the InPort register.
- Outputs derived from state, with no combinational path from ext_valid or InPortIn:
  - ext_ready = (count≠DEPTH)
  - data_avail = (count≠0)
- ext_data is ignored when ext_valid=0; the producer must hold data stable while valid && !ready.

## Timing
- Reset (Clear=0, async): wp=rp=0, count=0, InPort=0, underflow=0.
  - Resulting outputs: ext_ready=1, data_avail=0, BusMuxIn=0 (or InPort=0 if InPortOut=1).
- Reset mid-transfer discards all FIFO contents; a push on the edge coincident with reset release is accepted normally.
- Push-to-visible latency: a word accepted at edge N gives data_avail=1 after edge N. It can be popped at edge N+1 and driven on BusMuxIn after edge N+1.
- Pop latency: InPortIn at edge N puts the new InPort value on BusMuxIn (with InPortOut=1) immediately after edge N.
- Sustained throughput: one push and one pop per cycle.

## Configuration
- INPORT_STATUS_EN defined:
  - Adds input port `StatusOut` (1 bit).
  - When StatusOut=1 and InPortOut=0, BusMuxIn = {zeros, underflow, !ext_ready, !data_avail, count}, with count in bits [CW-1:0], empty at bit CW, full at CW+1, underflow at CW+2.
  - If InPortOut and StatusOut are both 1, InPortOut wins.
  - A status read does not clear underflow.
- Not defined: StatusOut port is absent; BusMuxIn depends only on InPortOut.

## Test plan
- Reset then idle:
  - Clear=0 for 2 cycles, release.
  - Required: ext_ready=1, data_avail=0, count=0, BusMuxIn=0 with InPortOut=1.
- Fill and drain, DEPTH=4:
  - Push 0x11,0x22,0x33,0x44 on consecutive cycles; 5th ext_valid sees ext_ready=0, count=4.
  - Four InPortIn+InPortOut pops yield BusMuxIn 0x11,0x22,0x33,0x44 in order.
- Wrap-around:
  - Push 3, pop 3, then push 0xA5A5A5A5, 0x5A5A5A5A.
  - Pops return them in order; count goes 2→1→0.
- Concurrent traffic:
  - With count=2, push 0x77 and InPortIn in the same cycle.
  - Required: count stays 2, InPort = oldest word, 0x77 popped after the remaining older word.
- Underflow:
  - InPortIn while empty: underflow=1, InPort unchanged (0 after reset).
  - Then push 0x99 and pop: InPort=0x99, underflow=0.
- Full with simultaneous pop; async reset mid-stream:
  - count=4, ext_valid=1, InPortIn=1: count=3 after the edge and the new word is not stored. The next edge stores it (count=4).
  - Assert Clear mid-stream: count=0 immediately, before the next edge.
